stage_memory_lsu: RTL and testbench
===================================

# stage_memory_lsu

Parametrised memory stage that replaces the plain execute→writeback register slice with a real load/store unit. Sits between the execute and writeback stages. Issues aligned byte/half/word(/double) accesses on a single-outstanding request/acknowledge data bus, stalls upstream while a bus transfer is in flight, and formats load data with sign or zero extension. Registers a single writeback result selected from ALU result, load data or return address.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ex_valid  in  1  execute-stage instruction present.
- ex_rd  in  REG_ADDR_W  destination register.
- ex_alu_result  in  XLEN  ALU result / effective byte address.
- ex_store_data  in  XLEN  store source operand, value in the low bits.
- ex_instr_addr_plus  in  XLEN  return address (pc+4).
- ex_mem_read, ex_mem_write  in  1 each  load / store; never both set.
- ex_funct3  in  3  access width and signedness code.
- ex_wr_enable  in  1  register write requested.
- ex_wb_sel  in  2  result source: ALU, MEM or PC_PLUS.
- mem_stall  out  1  execute must hold its outputs this cycle.
- dbus_req, dbus_we  out  1 each  request valid / write.
- dbus_addr  out  XLEN  byte address.
- dbus_wdata  out  XLEN  write data, lane-replicated.
- dbus_be  out  XLEN/8  byte enables.
- dbus_ack  in  1  transfer complete; rdata valid this cycle for reads.
- dbus_rdata  in  XLEN  read data, full word.
- mem_valid, mem_wr_enable  out  1 each  writeback instruction valid / register write.
- mem_rd  out  REG_ADDR_W  destination register.
- mem_result  out  XLEN  selected writeback value.
- mem_misaligned  out  1  exception flag for a misaligned access.

## Operation
- FSM states: IDLE, BUSY.
- IDLE, ex_valid=1, no memory access:
  - Next edge registers rd, wr_enable and the wb_sel-selected value into the mem_* outputs.
  - mem_valid becomes 1.
- IDLE, ex_valid=1, aligned memory access:
  - Next edge captures the access.
  - Drives dbus_req=1 with addr, we, wdata and be, registered.
  - Moves to BUSY.
  - mem_valid becomes 0.
- BUSY:
  - mem_stall=1, including the ack cycle.
  - Bus outputs held stable.
  - mem_valid=0.
- BUSY with dbus_ack=1:
  - Next edge clears dbus_req and returns to IDLE.
  - Writes the result and mem_valid=1.
  - Load: mem_result is the formatted rdata and mem_wr_enable is the captured value.
  - Store: mem_wr_enable=0.
- Misaligned access (half not 2-aligned, word not 4-aligned, double not 8-aligned):
  - No bus request.
  - Next edge sets mem_valid=1, mem_misaligned=1, mem_wr_enable=0, mem_result=address.
- IDLE with ex_valid=0: mem_valid=0 next edge; other mem_* outputs hold.
- Widths:
  - Lane offset is addr[log2(XLEN/8)-1:0].
  - Byte access: be = 1<<off.
  - Half access: be = 2'b11<<off.
  - Word access: be = 4'hF<<off.
  - Double access: all ones.
  - wdata replicates the low byte/half/word across all lanes.
- Loads:
  - Select the lane at off.
  - LB, LH and LW (the last when XLEN=64) sign-extend to XLEN.
  - LBU, LHU and LWU zero-extend.
- Undefined funct3 codes (and 011/110 when XLEN=32) are treated as full-XLEN accesses.
- wb_sel=3 is treated as ALU.
- dbus_ack seen in IDLE is ignored.

## Timing
- Reset values:
  - State IDLE.
  - dbus_req, dbus_we and mem_stall are 0.
  - All remaining outputs are 0, including dbus_addr, wdata, be and mem_result.
- Reset mid-BUSY: request dropped next edge; no writeback produced.
- Latency, non-memory instructions: 1 cycle, back-to-back throughput.
- Latency, memory access: dbus_req asserts 1 cycle after capture.
  - Result appears on the edge after dbus_ack.
  - With zero-wait ack, mem_valid follows capture by 2 cycles.
- mem_stall is combinational from state only (no dbus_ack path).
- The instruction held by execute is consumed on the first IDLE cycle after BUSY.

## Structure
- Shared package lsu_pkg: wb_sel enum (WB_ALU, WB_MEM, WB_PC_PLUS) and funct3 width constants (F3_LB … F3_LWU).
- One combinational sub-module, mem_lane_align: produces store be/wdata and load extraction/extension, parametrised on XLEN.

## Test plan
- Reset: assert rst for 2 cycles with dbus_ack=1 → all outputs 0, state IDLE; ack ignored.
- ALU stream: three back-to-back ex_valid instructions, wb_sel=ALU, results 0x11, 0x22, 0x33 → mem_result shows 0x11, 0x22, 0x33 on consecutive cycles, mem_stall never set.
- LB signed: addr 0x1003, rdata 0x80FF_FF7F, ack 2 cycles after req → dbus_be=4'b1000, mem_result=0xFFFF_FF80, stall for exactly the BUSY cycles.
- SH: addr 0x2002, store_data 0x0000_BEEF → dbus_we=1, be=4'b1100, wdata=0xBEEF_BEEF, mem_wr_enable=0 on completion.
- Misaligned LW at 0x3001 → no dbus_req, mem_misaligned=1, mem_result=0x3001 next cycle.
- JAL: wb_sel=PC_PLUS, instr_addr_plus=0x104, rd=1 → mem_result=0x104. Separately, rst asserted during BUSY → dbus_req=0 next cycle and no writeback.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and access-width helpers for the memory stage
package lsu_pkg;

    typedef enum logic [1:0] {
        WB_ALU     = 2'd0,
        WB_MEM     = 2'd1,
        WB_PC_PLUS = 2'd2
    } wb_sel_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // log2 of the access size in bytes; anything not a narrow access is full width
    function automatic logic [1:0] access_size(input logic [2:0] f3, input int xlen);
        logic [1:0] full;
        full = (xlen == 64) ? 2'd3 : 2'd2;
        case (f3)
            F3_LB, F3_LBU: access_size = 2'd0;
            F3_LH, F3_LHU: access_size = 2'd1;
            F3_LW, F3_LWU: access_size = 2'd2;
            default:       access_size = full;
        endcase
    endfunction

endpackage

// File: rtl/stage_memory_lsu_if.sv
// rtl/stage_memory_lsu_if.sv - single-outstanding request/acknowledge data bus
interface stage_memory_lsu_if #(
    parameter int XLEN = 32
);
    logic              req;
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] be;
    logic              ack;
    logic [XLEN-1:0]   rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane placement and load extraction/extension
module mem_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [2:0]                funct3,
    input  logic [XLEN-1:0]           store_data,
    input  logic [XLEN-1:0]           rdata,
    output logic [XLEN/8-1:0]         be,
    output logic [XLEN-1:0]           wdata,
    output logic [XLEN-1:0]           load_data,
    output logic                      misaligned
);
    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);

    logic [1:0]       size;
    logic [OFF_W-1:0] mask;
    logic [XLEN-1:0]  lane;

    assign size       = access_size(funct3, XLEN);
    assign mask       = OFF_W'((4'b0001 << size) - 4'b0001);
    assign misaligned = |(off & mask);
    assign lane       = rdata >> {off, 3'b000};

    always_comb begin
        be    = '1;
        wdata = store_data;
        case (size)
            2'd0: begin
                be    = BE_W'(1) << off;
                wdata = {BE_W{store_data[7:0]}};
            end
            2'd1: begin
                be    = BE_W'(2'b11) << off;
                wdata = {(XLEN/16){store_data[15:0]}};
            end
            2'd2: begin
                be    = BE_W'(4'hF) << off;
                wdata = {(XLEN/32){store_data[31:0]}};
            end
            default: begin
                be    = '1;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        load_data = lane;
        case (funct3)
            F3_LB:   load_data = XLEN'($signed(lane[7:0]));
            F3_LH:   load_data = XLEN'($signed(lane[15:0]));
            F3_LW:   load_data = XLEN'($signed(lane[31:0]));
            F3_LBU:  load_data = XLEN'(lane[7:0]);
            F3_LHU:  load_data = XLEN'(lane[15:0]);
            F3_LWU:  load_data = XLEN'(lane[31:0]);
            default: load_data = lane;
        endcase
    end

endmodule

// File: rtl/stage_memory_lsu.sv
// rtl/stage_memory_lsu.sv - memory stage load/store unit between execute and writeback
module stage_memory_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [XLEN-1:0]       ex_store_data,
    input  logic [XLEN-1:0]       ex_instr_addr_plus,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [2:0]            ex_funct3,
    input  logic                  ex_wr_enable,
    input  logic [1:0]            ex_wb_sel,
    output logic                  mem_stall,
    stage_memory_lsu_if.master    dbus,
    output logic                  mem_valid,
    output logic                  mem_wr_enable,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [XLEN-1:0]       mem_result,
    output logic                  mem_misaligned
);
    localparam int OFF_W = $clog2(XLEN/8);

    lsu_state_e state, state_nx;

    logic                  busy;
    logic                  is_mem;
    logic [OFF_W-1:0]      al_off;
    logic [2:0]            al_f3;
    logic [XLEN/8-1:0]     al_be;
    logic [XLEN-1:0]       al_wdata;
    logic [XLEN-1:0]       al_load;
    logic                  al_misaligned;
    logic [XLEN-1:0]       wb_value;

    logic                  cap_read;
    logic                  cap_wr_enable;
    logic [REG_ADDR_W-1:0] cap_rd;
    logic [2:0]            cap_f3;

    assign busy      = (state == S_BUSY);
    assign is_mem    = ex_mem_read | ex_mem_write;
    assign mem_stall = busy;

    // While busy the aligner formats the returning load from the captured access
    assign al_off = busy ? dbus.addr[OFF_W-1:0] : ex_alu_result[OFF_W-1:0];
    assign al_f3  = busy ? cap_f3 : ex_funct3;

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .off        (al_off),
        .funct3     (al_f3),
        .store_data (ex_store_data),
        .rdata      (dbus.rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_misaligned)
    );

    always_comb begin
        wb_value = ex_alu_result;
        if (ex_wb_sel == WB_PC_PLUS) begin
            wb_value = ex_instr_addr_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (ex_valid && is_mem && !al_misaligned) state_nx = S_BUSY;
            S_BUSY:  if (dbus.ack) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbus.req       <= 1'b0;
            dbus.we        <= 1'b0;
            dbus.addr      <= '0;
            dbus.wdata     <= '0;
            dbus.be        <= '0;
            mem_valid      <= 1'b0;
            mem_wr_enable  <= 1'b0;
            mem_rd         <= '0;
            mem_result     <= '0;
            mem_misaligned <= 1'b0;
            cap_read       <= 1'b0;
            cap_wr_enable  <= 1'b0;
            cap_rd         <= '0;
            cap_f3         <= '0;
        end else if (busy) begin
            mem_valid <= 1'b0;
            if (dbus.ack) begin
                dbus.req       <= 1'b0;
                dbus.we        <= 1'b0;
                mem_valid      <= 1'b1;
                mem_rd         <= cap_rd;
                mem_misaligned <= 1'b0;
                mem_wr_enable  <= cap_read & cap_wr_enable;
                if (cap_read) begin
                    mem_result <= al_load;
                end
            end
        end else if (ex_valid && is_mem && !al_misaligned) begin
            dbus.req      <= 1'b1;
            dbus.we       <= ex_mem_write;
            dbus.addr     <= ex_alu_result;
            dbus.wdata    <= al_wdata;
            dbus.be       <= al_be;
            cap_read      <= ex_mem_read;
            cap_wr_enable <= ex_wr_enable;
            cap_rd        <= ex_rd;
            cap_f3        <= ex_funct3;
            mem_valid     <= 1'b0;
        end else if (ex_valid && is_mem) begin
            // Misaligned: report the faulting address instead of touching the bus
            mem_valid      <= 1'b1;
            mem_misaligned <= 1'b1;
            mem_wr_enable  <= 1'b0;
            mem_rd         <= ex_rd;
            mem_result     <= ex_alu_result;
        end else if (ex_valid) begin
            mem_valid      <= 1'b1;
            mem_misaligned <= 1'b0;
            mem_wr_enable  <= ex_wr_enable;
            mem_rd         <= ex_rd;
            mem_result     <= wb_value;
        end else begin
            mem_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_memory_lsu.sv
// tb/tb_stage_memory_lsu.sv - scoreboard bench for stage_memory_lsu
module tb_stage_memory_lsu;
    import lsu_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] result;
        logic        mis;
        logic        chk_full;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] rdata;
    } bus_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [31:0] ex_instr_addr_plus;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        ex_wr_enable;
    logic [1:0]  ex_wb_sel;
    logic        mem_stall;
    logic        mem_valid;
    logic        mem_wr_enable;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        mem_misaligned;
    logic        ack_resp;
    logic        ack_force;

    int n_checks = 0;
    int n_pass   = 0;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];

    stage_memory_lsu_if #(.XLEN(32)) dbus ();
    assign dbus.ack = ack_resp | ack_force;

    stage_memory_lsu #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk                (clk),
        .rst                (rst),
        .ex_valid           (ex_valid),
        .ex_rd              (ex_rd),
        .ex_alu_result      (ex_alu_result),
        .ex_store_data      (ex_store_data),
        .ex_instr_addr_plus (ex_instr_addr_plus),
        .ex_mem_read        (ex_mem_read),
        .ex_mem_write       (ex_mem_write),
        .ex_funct3          (ex_funct3),
        .ex_wr_enable       (ex_wr_enable),
        .ex_wb_sel          (ex_wb_sel),
        .mem_stall          (mem_stall),
        .dbus               (dbus),
        .mem_valid          (mem_valid),
        .mem_wr_enable      (mem_wr_enable),
        .mem_rd             (mem_rd),
        .mem_result         (mem_result),
        .mem_misaligned     (mem_misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic exp_wb(input logic [4:0] rd, input logic wr, input logic [31:0] result,
                          input logic mis, input logic chk_full);
        wb_exp_t e;
        e.rd = rd; e.wr = wr; e.result = result; e.mis = mis; e.chk_full = chk_full;
        wb_q.push_back(e);
    endtask

    task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int lat, input logic [31:0] rdata);
        bus_exp_t b;
        b.we = we; b.addr = addr; b.wdata = wdata; b.be = be; b.lat = lat; b.rdata = rdata;
        bus_q.push_back(b);
    endtask

    // Called at posedge+1; holds the instruction across exactly one capture edge
    task automatic issue(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [31:0] pc4, input logic rd_m, input logic wr_m,
                         input logic [2:0] f3, input logic wen, input logic [1:0] wb);
        ex_valid = 1'b1; ex_rd = rd; ex_alu_result = alu; ex_store_data = sd;
        ex_instr_addr_plus = pc4; ex_mem_read = rd_m; ex_mem_write = wr_m;
        ex_funct3 = f3; ex_wr_enable = wen; ex_wb_sel = wb;
        @(negedge clk);
        check("stall_at_issue", mem_stall, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mem_wait(input int exp_busy);
        int cnt;
        cnt = 0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_stall) cnt++;
            else break;
        end
        check("busy_cycles", cnt, exp_busy);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && mem_valid) begin
                if (wb_q.size() == 0) begin
                    check("unexpected_wb", mem_valid, 0);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_wr_enable", mem_wr_enable, e.wr);
                    check("wb_misaligned", mem_misaligned, e.mis);
                    if (e.chk_full) begin
                        check("wb_rd", mem_rd, e.rd);
                        check("wb_result", mem_result, e.result);
                    end
                end
            end
        end
    end

    initial begin : responder
        bus_exp_t b;
        int   lat;
        logic seen;
        seen = 1'b0; lat = 0; ack_resp = 1'b0; dbus.rdata = '0;
        forever begin
            @(negedge clk);
            if (dbus.req && !rst) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (bus_q.size() == 0) begin
                        check("unexpected_req", dbus.req, 0);
                        lat = 0;
                    end else begin
                        b = bus_q.pop_front();
                        check("bus_we", dbus.we, b.we);
                        check("bus_addr", dbus.addr, b.addr);
                        check("bus_be", dbus.be, b.be);
                        check("bus_wdata", dbus.wdata, b.wdata);
                        lat = b.lat;
                        dbus.rdata = b.rdata;
                    end
                end
                check("stall_in_busy", mem_stall, 1);
                if (lat == 0) begin
                    ack_resp = 1'b1;
                end else begin
                    lat--;
                    ack_resp = 1'b0;
                end
            end else begin
                seen = 1'b0;
                ack_resp = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        rst = 1'b1; ack_force = 1'b1;
        ex_valid = 1'b0; ex_rd = '0; ex_alu_result = '0; ex_store_data = '0;
        ex_instr_addr_plus = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_funct3 = '0; ex_wr_enable = 1'b0; ex_wb_sel = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", dbus.req, 0);
        check("rst_we", dbus.we, 0);
        check("rst_addr", dbus.addr, 0);
        check("rst_wdata", dbus.wdata, 0);
        check("rst_be", dbus.be, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_valid", mem_valid, 0);
        check("rst_result", mem_result, 0);
        check("rst_wr_enable", mem_wr_enable, 0);
        check("rst_misaligned", mem_misaligned, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_ack_stall", mem_stall, 0);
        @(posedge clk);
        #1;
        check("idle_ack_req", dbus.req, 0);
        ack_force = 1'b0;

        // Back-to-back ALU results, then return address and wb_sel=3
        exp_wb(5'd3, 1'b1, 32'h11, 1'b0, 1'b1);
        exp_wb(5'd4, 1'b1, 32'h22, 1'b0, 1'b1);
        exp_wb(5'd5, 1'b1, 32'h33, 1'b0, 1'b1);
        exp_wb(5'd1, 1'b1, 32'h104, 1'b0, 1'b1);
        exp_wb(5'd6, 1'b1, 32'h55, 1'b0, 1'b1);
        issue(5'd3, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0, F3_LW, 1'b1, WB_ALU);
        issue(5'd4, 32'h22, 32'h0, 32'h0, 1'b0, 1'b0, F3_LW, 1'b1, WB_ALU);
        issue(5'd5, 32'h33, 32'h0, 32'h0, 1'b0, 1'b0, F3_LW, 1'b1, WB_ALU);
        issue(5'd1, 32'hDEAD, 32'h0, 32'h104, 1'b0, 1'b0, F3_LW, 1'b1, WB_PC_PLUS);
        issue(5'd6, 32'h55, 32'h0, 32'h999, 1'b0, 1'b0, F3_LW, 1'b1, 2'd3);
        idle(1);

        // Loads: sign and zero extension from each lane
        exp_bus(1'b0, 32'h1003, 32'h0, 4'b1000, 2, 32'h80FF_FF7F);
        exp_wb(5'd7, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1);
        issue(5'd7, 32'h1003, 32'h0, 32'h0, 1'b1, 1'b0, F3_LB, 1'b1, WB_MEM);
        mem_wait(3);

        exp_bus(1'b0, 32'h1001, 32'h0, 4'b0010, 0, 32'h0000_9A00);
        exp_wb(5'd8, 1'b1, 32'h0000_009A, 1'b0, 1'b1);
        issue(5'd8, 32'h1001, 32'h0, 32'h0, 1'b1, 1'b0, F3_LBU, 1'b1, WB_MEM);
        mem_wait(1);

        exp_bus(1'b0, 32'h1002, 32'h0, 4'b1100, 1, 32'h8001_0000);
        exp_wb(5'd9, 1'b1, 32'hFFFF_8001, 1'b0, 1'b1);
        issue(5'd9, 32'h1002, 32'h0, 32'h0, 1'b1, 1'b0, F3_LH, 1'b1, WB_MEM);
        mem_wait(2);

        exp_bus(1'b0, 32'h1002, 32'h0, 4'b1100, 0, 32'hF00D_0000);
        exp_wb(5'd10, 1'b1, 32'h0000_F00D, 1'b0, 1'b1);
        issue(5'd10, 32'h1002, 32'h0, 32'h0, 1'b1, 1'b0, F3_LHU, 1'b1, WB_MEM);
        mem_wait(1);

        exp_bus(1'b0, 32'h1004, 32'h0, 4'b1111, 0, 32'h1234_5678);
        exp_wb(5'd11, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
        issue(5'd11, 32'h1004, 32'h0, 32'h0, 1'b1, 1'b0, F3_LW, 1'b1, WB_MEM);
        mem_wait(1);

        exp_bus(1'b0, 32'h1008, 32'h0, 4'b1111, 0, 32'h89AB_CDEF);
        exp_wb(5'd12, 1'b1, 32'h89AB_CDEF, 1'b0, 1'b1);
        issue(5'd12, 32'h1008, 32'h0, 32'h0, 1'b1, 1'b0, F3_LD, 1'b1, WB_MEM);
        mem_wait(1);

        // Stores: lane replication, byte enables, no register write
        exp_bus(1'b1, 32'h2002, 32'hBEEF_BEEF, 4'b1100, 1, 32'h0);
        exp_wb(5'd13, 1'b0, 32'h0, 1'b0, 1'b0);
        issue(5'd13, 32'h2002, 32'h0000_BEEF, 32'h0, 1'b0, 1'b1, F3_LH, 1'b1, WB_ALU);
        mem_wait(2);

        exp_bus(1'b1, 32'h2001, 32'hA5A5_A5A5, 4'b0010, 0, 32'h0);
        exp_wb(5'd14, 1'b0, 32'h0, 1'b0, 1'b0);
        issue(5'd14, 32'h2001, 32'h1234_56A5, 32'h0, 1'b0, 1'b1, F3_LB, 1'b1, WB_ALU);
        mem_wait(1);

        exp_bus(1'b1, 32'h2004, 32'hCAFE_F00D, 4'b1111, 0, 32'h0);
        exp_wb(5'd15, 1'b0, 32'h0, 1'b0, 1'b0);
        issue(5'd15, 32'h2004, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, F3_LW, 1'b1, WB_ALU);
        mem_wait(1);

        // Misaligned accesses: no bus request, address reported next cycle
        exp_wb(5'd16, 1'b0, 32'h3001, 1'b1, 1'b1);
        exp_wb(5'd17, 1'b0, 32'h2003, 1'b1, 1'b1);
        exp_wb(5'd18, 1'b1, 32'h77, 1'b0, 1'b1);
        issue(5'd16, 32'h3001, 32'h0, 32'h0, 1'b1, 1'b0, F3_LW, 1'b1, WB_MEM);
        issue(5'd17, 32'h2003, 32'h0, 32'h0, 1'b0, 1'b1, F3_LH, 1'b1, WB_ALU);
        issue(5'd18, 32'h77, 32'h0, 32'h0, 1'b0, 1'b0, F3_LW, 1'b1, WB_ALU);
        idle(2);

        // Reset while the bus transfer is outstanding
        exp_bus(1'b0, 32'h4000, 32'h0, 4'b1111, 10, 32'h0);
        issue(5'd19, 32'h4000, 32'h0, 32'h0, 1'b1, 1'b0, F3_LW, 1'b1, WB_MEM);
        idle(2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy_req", dbus.req, 0);
        check("rst_busy_stall", mem_stall, 0);
        check("rst_busy_valid", mem_valid, 0);
        @(posedge clk);
        #1;
        idle(4);

        exp_wb(5'd20, 1'b1, 32'h99, 1'b0, 1'b1);
        issue(5'd20, 32'h99, 32'h0, 32'h0, 1'b0, 1'b0, F3_LW, 1'b1, WB_ALU);
        idle(4);

        check("wb_queue_drained", wb_q.size(), 0);
        check("bus_queue_drained", bus_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
